// File: rtl/fir_pkg.sv
// Shared widths, FIR geometry and reader state type for the FIR output path.
package fir_pkg;

    localparam int FIR_IN_W  = 4;
    localparam int FIR_OUT_W = 10;
    localparam int FIR_TAPS  = 9;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } fir_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO: registered count, head read straight from storage.
module fir_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rptr];

    // Storage carries no reset; consumers only look at head while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_reader.sv
// Drops the filter's warm-up samples, then buffers output samples for a
// ready/valid consumer, counting samples lost to a full buffer.
module fir_out_reader
    import fir_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WARMUP = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [FIR_OUT_W-1:0]     Data_in,
    input  logic                     in_valid,
    output logic [FIR_OUT_W-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     warmup_done,
    output logic [7:0]               overflow_cnt
);
    localparam fir_state_e RST_STATE = (WARMUP == 0) ? RUN : WARM;

    fir_state_e            state;
    logic [7:0]            warm_cnt;
    logic                  push, pop, full, empty;
    logic [FIR_OUT_W-1:0]  head;

    assign out_valid   = ~empty;
    assign out_data    = out_valid ? head : '0;
    assign pop         = out_valid & out_ready;
    assign push        = (state == RUN) & in_valid & (~full | pop);
    assign warmup_done = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RST_STATE;
            warm_cnt     <= '0;
            overflow_cnt <= '0;
        end else if (state == WARM) begin
            if (in_valid) begin
                warm_cnt <= warm_cnt + 8'd1;
                if (warm_cnt + 8'd1 == 8'(WARMUP))
                    state <= RUN;
            end
        end else if (in_valid & full & ~pop) begin
            overflow_cnt <= sat_inc8(overflow_cnt);
        end
    end

    fir_sync_fifo #(
        .WIDTH (FIR_OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (Data_in),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_fir_out_reader.sv
// Directed bench for fir_out_reader: a warm-up/drain vector table plus
// hand sequences for overflow, full pass-through, saturation and reset.
module tb_fir_out_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data;
    logic       in_valid, out_ready;
    logic [9:0] out_data;
    logic       out_valid, warmup_done;
    logic [3:0] count;
    logic [7:0] overflow_cnt;

    logic       z_in_valid, z_out_ready;
    logic [9:0] z_data, z_out_data;
    logic       z_out_valid, z_done;
    logic [1:0] z_count;
    logic [7:0] z_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_out_reader #(.DEPTH(8), .WARMUP(8)) dut (
        .clk(clk), .reset(reset), .Data_in(data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .warmup_done(warmup_done), .overflow_cnt(overflow_cnt)
    );

    fir_out_reader #(.DEPTH(2), .WARMUP(0)) dut_z (
        .clk(clk), .reset(reset), .Data_in(z_data), .in_valid(z_in_valid),
        .out_data(z_out_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .count(z_count), .warmup_done(z_done), .overflow_cnt(z_ovf)
    );

    typedef struct {
        logic       iv;
        logic [9:0] d;
        logic       rdy;
        logic       ev;
        logic [9:0] ed;
        int         ec;
        logic       edone;
        int         eovf;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [9:0] d, input logic rdy);
        in_valid  = iv;
        data      = d;
        out_ready = rdy;
    endtask

    task automatic chk_all(input string tag, input logic ev, input int ed, input int ec,
                           input logic edone, input int eovf);
        chk({tag, " out_valid"},    int'(out_valid),    int'(ev));
        chk({tag, " out_data"},     int'(out_data),     ed);
        chk({tag, " count"},        int'(count),        ec);
        chk({tag, " warmup_done"},  int'(warmup_done),  int'(edone));
        chk({tag, " overflow_cnt"}, int'(overflow_cnt), eovf);
    endtask

    initial begin
        // Warm-up of Data_in=1..12 with the consumer stalled, then drain.
        for (int i = 1; i <= 12; i++)
            tbl[i-1] = '{iv: 1'b1, d: 10'(i), rdy: 1'b0,
                         ev: (i >= 9), ed: (i >= 9) ? 10'd9 : 10'd0,
                         ec: (i >= 9) ? i - 8 : 0, edone: (i >= 8), eovf: 0};
        tbl[12] = '{1'b0, 10'd0, 1'b1, 1'b1, 10'd10, 3, 1'b1, 0};
        tbl[13] = '{1'b0, 10'd0, 1'b1, 1'b1, 10'd11, 2, 1'b1, 0};
        tbl[14] = '{1'b0, 10'd0, 1'b1, 1'b1, 10'd12, 1, 1'b1, 0};
        tbl[15] = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd0,  0, 1'b1, 0};
        tbl[16] = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd0,  0, 1'b1, 0};

        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        z_in_valid = 1'b0; z_data = '0; z_out_ready = 1'b0;
        #12;
        chk_all("reset", 1'b0, 0, 0, 1'b0, 0);
        chk("reset z warmup_done", int'(z_done), 1);
        @(negedge clk);
        reset = 1'b0;

        // WARMUP=0 instance stores from the first pulse; DEPTH=2 fills fast.
        z_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            z_data = 10'(5 + i);
            step();
        end
        z_in_valid = 1'b0;
        chk("z count", int'(z_count), 2);
        chk("z overflow", int'(z_ovf), 1);
        chk("z head", int'(z_out_data), 5);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].rdy);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].ev, int'(tbl[i].ed), tbl[i].ec,
                    tbl[i].edone, tbl[i].eovf);
        end

        // Single push into empty: no bypass, visible one cycle later.
        drive(1'b1, 10'h3FF, 1'b1);
        #1;
        chk("bypass out_valid", int'(out_valid), 0);
        step();
        drive(1'b0, '0, 1'b0);
        chk_all("push3ff", 1'b1, 'h3FF, 1, 1'b1, 0);
        out_ready = 1'b1;
        step();
        chk("pop3ff count", int'(count), 0);

        // Ten pushes into an 8-deep FIFO: two drops, first eight survive.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 10'(100 + i), 1'b0);
            step();
        end
        chk_all("overflow", 1'b1, 100, 8, 1'b1, 2);
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), int'(out_data), 100 + i);
            step();
        end
        chk("drained count", int'(count), 0);

        // Full FIFO with push and pop together: stream continues, no drops.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10'(200 + i), 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 10'(208 + i), 1'b1);
            #1;
            chk($sformatf("thru%0d data", i), int'(out_data), 200 + i);
            step();
            chk($sformatf("thru%0d count", i), int'(count), 8);
        end
        chk("thru overflow", int'(overflow_cnt), 2);
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tail%0d", i), int'(out_data), 220 + i);
            step();
        end

        // 300 drops on a full FIFO: counter stops at 255, contents intact.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10'(300 + i), 1'b0);
            step();
        end
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 10'(900), 1'b0);
            step();
            if (i == 252) chk("ovf 252", int'(overflow_cnt), 254);
            if (i == 253) chk("ovf 253", int'(overflow_cnt), 255);
        end
        chk_all("saturate", 1'b1, 300, 8, 1'b1, 255);

        // Build count=5, overflow=3 from a fresh warm-up, then reset mid-cycle.
        drive(1'b0, '0, 1'b0);
        reset = 1'b1;
        #1;
        chk_all("reset2", 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 10'(400 + i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk_all("pre-reset", 1'b1, 411, 5, 1'b1, 3);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid reset", 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 10'(500 + i), 1'b0);
            step();
            if (i < 8)
                chk($sformatf("rewarm%0d count", i), int'(count), 0);
            chk($sformatf("rewarm%0d done", i), int'(warmup_done), int'(i >= 7));
        end
        chk_all("rewarm stored", 1'b1, 508, 1, 1'b1, 0);
        drive(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_out_reader.md
FIR_OUT_READER -- requirements
Module: fir_out_reader

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 Parameter WARMUP, default 8: number of accepted input samples discarded after reset while the filter delay line fills; range 0..255.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 Data_in  input  10: filter output sample, unsigned.
REQ-006 in_valid  input  1: Data_in carries a new sample this cycle; no back-pressure to the source.
REQ-007 out_data  output  10: FIFO head sample, valid only while out_valid=1.
REQ-008 out_valid  output  1: FIFO non-empty.
REQ-009 out_ready  input  1: consumer accepts out_data this cycle.
REQ-010 count  output  $clog2(DEPTH)+1: number of stored entries.
REQ-011 warmup_done  output  1: warm-up discard phase has finished.
REQ-012 overflow_cnt  output  8: number of samples dropped because the FIFO was full; saturates.

Function
REQ-013 The block SHALL have two states: WARM and RUN.
- Reset enters WARM.
- If WARMUP=0, reset enters RUN directly.
REQ-014 In WARM, every in_valid sample SHALL be discarded and SHALL increment warm_cnt; the state SHALL move to RUN on the cycle warm_cnt reaches WARMUP.
- Example: WARMUP=8 with in_valid held high gives the first stored sample on the 9th pulse.
REQ-015 warmup_done SHALL equal (state==RUN), registered.
REQ-016 In RUN, a sample is pushed when in_valid=1 and (count<DEPTH or pop this cycle).
REQ-017 A pop occurs when out_valid=1 and out_ready=1.
REQ-018 Push-to-visibility latency SHALL be 1 cycle: out_valid rises the cycle after a push into an empty FIFO; there is no combinational bypass.
REQ-019 out_data SHALL be show-ahead: it presents the head entry whenever out_valid=1 and is stable until popped.
REQ-020 When full with no pop, in_valid SHALL drop the sample, leave the FIFO contents unchanged, and increment overflow_cnt, which saturates at 255.
REQ-021 When full with a simultaneous pop, the push SHALL be accepted; count stays DEPTH and overflow_cnt is unchanged.
REQ-022 When empty, out_ready SHALL be ignored and count SHALL never underflow.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-024 count changes by +1, -1 or 0 per cycle; a simultaneous push and pop leaves it unchanged.
REQ-025 Samples SHALL leave in arrival order, bit-exact; no arithmetic is applied to data.

Reset
REQ-026 Asserting reset at any time, including mid-warm-up or with the FIFO partially full, SHALL immediately set:
- state=WARM (or RUN if WARMUP=0)
- warm_cnt=0, count=0, pointers=0
- out_valid=0, out_data=0, overflow_cnt=0, warmup_done=0 (1 if WARMUP=0)
REQ-027 Stored entries need no reset; out_data SHALL be forced to 0 while out_valid=0.
REQ-028 The first rising edge after reset deassertion SHALL be able to sample in_valid.

Structure
REQ-029 Package fir_pkg SHALL hold:
- FIR_IN_W=4, FIR_OUT_W=10, FIR_TAPS=9
- state enumeration type {WARM, RUN}
REQ-030 Storage and pointers SHALL live in one sub-module, fir_sync_fifo (parameters WIDTH, DEPTH), which exposes push, pop, full, empty, count and head.
REQ-031 The warm-up FSM, drop logic and overflow counter SHALL reside in fir_out_reader.

Verification
REQ-032 Reset, WARMUP=8, in_valid high with Data_in=1..12 and out_ready=0 -> pulses 1..8 discarded; warmup_done rises after pulse 8; FIFO holds 9,10,11,12 and count=4.
REQ-033 RUN, DEPTH=8, 10 pushes of 100..109 with out_ready=0 -> count=8, overflow_cnt=2; draining yields 100..107.
REQ-034 Full FIFO, in_valid=1 and out_ready=1 for 20 cycles with incrementing data -> no drops; count stays 8; output stream continuous and in order.
REQ-035 Empty FIFO, a single push of 0x3FF -> out_valid=1 and out_data=0x3FF exactly one cycle later; out_ready=1 while empty has no effect.
REQ-036 Reset pulse asserted mid-cycle with count=5 and overflow_cnt=3 -> all outputs zero immediately, warm-up restarts, and the next 8 samples are discarded.
REQ-037 300 overflow drops -> overflow_cnt holds at 255.
